// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the fetch front end's memory, redirect and decode-side
// signals.
//   master : the fetch_queue itself (drives imem_req/addr, out_*, hlt)
//   slave  : the environment (memory, PC control, decode)
interface fetch_queue_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_valid;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              hlt;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, hlt,
    input  imem_valid, imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, hlt,
    output imem_valid, imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. A small FSM issues one request at a
// time to instruction memory, pushes each returned instruction with its PC into
// a DEPTH-entry FIFO, and stops fetching once a HLT opcode is fetched.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fetch_queue_if.master
//                imem_req/imem_addr/imem_valid/imem_rdata - memory handshake
//                redirect/redirect_pc                     - flush + new PC
//                out_valid/out_ready/out_instr/out_pc     - decode handshake
//                hlt                                      - fetch stopped, drained
module fetch_queue #(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 16,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HLT_OP   = 4'hF
) (
  input  logic clk,
  input  logic rst_n,
  fetch_queue_if.master bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {RUN, WAIT, DROP, HALT} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  state_t            state, state_nxt;
  entry_t            fifo [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] fetch_pc, addr_q;
  logic              push, pop, launch, full, is_hlt;

  assign full   = (count == CNT_W'(DEPTH));
  assign is_hlt = (bus.imem_rdata[DATA_W-1 -: 4] == HLT_OP);

  // Redirect discards any same-cycle pop so the flushed head is never consumed.
  assign pop = (count != '0) && bus.out_ready && !bus.redirect;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    launch    = 1'b0;
    case (state)
      RUN: begin
        if (!bus.redirect && !full) begin
          state_nxt = WAIT;
          launch    = 1'b1;
        end
      end
      WAIT: begin
        if (bus.redirect)
          // Response already here: drop it. Otherwise it is still owed.
          state_nxt = bus.imem_valid ? RUN : DROP;
        else if (bus.imem_valid) begin
          push      = 1'b1;
          state_nxt = is_hlt ? HALT : RUN;
        end
      end
      DROP: begin
        // The owed response retires the flushed request even if another
        // redirect lands in the same cycle; waiting on would never end.
        if (bus.imem_valid) state_nxt = RUN;
      end
      HALT: begin
        if (bus.redirect) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (bus.redirect)  fetch_pc <= bus.redirect_pc;
      else if (push)     fetch_pc <= fetch_pc + ADDR_W'(2);
      if (launch)        addr_q   <= fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Payload storage needs no reset; out_valid qualifies it.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{pc: fetch_pc, instr: bus.imem_rdata};
  end

  assign bus.imem_req  = (state == WAIT) || (state == DROP);
  assign bus.imem_addr = addr_q;
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = fifo[rd_ptr].instr;
  assign bus.out_pc    = fifo[rd_ptr].pc;
  assign bus.hlt       = (state == HALT) && (count == '0);

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized bench for fetch_queue. The driver plays memory,
// PC control and decode; a reference model tracks the expected program-order
// stream (next PC, queued {pc,instr}, halted) and a negedge monitor pops and
// compares every entry decode accepts.
module tb_fetch_queue;
  localparam int          DATA_W = 16;
  localparam int          ADDR_W = 16;
  localparam int          DEPTH  = 4;
  localparam logic [15:0] RST_PC = 16'hFFFE;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  fetch_queue #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .RESET_PC(RST_PC), .HLT_OP(4'hF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // reference model
  logic [31:0] exp_q[$];
  logic [15:0] model_pc;
  bit          halted;
  int          exp_cnt;
  bit          exp_hlt;
  bit          in_rst = 1'b1;

  // memory responder
  bit          outst, live, vld_last;
  int          wait_cnt;
  logic [15:0] req_addr;

  // knobs
  int          lat_min = 1, lat_max = 1, ready_pct = 100, redir_pct = 0, spur_pct = 0;
  logic [15:0] halt_addr = 16'hFFFF;
  bit          f_wait, f_valid, f_any;
  logic [15:0] f_pc;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == halt_addr) ? 16'hF000 : 16'h1000 + a;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    model_pc = RST_PC;
    halted   = 1'b0;
    outst    = 1'b0;
    live     = 1'b0;
    vld_last = 1'b0;
    exp_cnt  = 0;
    exp_hlt  = 1'b0;
  endtask

  task automatic step();
    bit          vld, rd, dead;
    logic [15:0] rpc, d, tmp;
    @(posedge clk); #1;
    exp_cnt = exp_q.size();
    exp_hlt = halted && (exp_q.size() == 0);
    if (vld_last) begin
      chk("req_after_resp", bus.imem_req, 0);
      outst = 1'b0;
    end
    if (bus.imem_req) begin
      if (!outst) begin
        chk("req_addr", bus.imem_addr, model_pc);
        chk("req_while_halted", halted, 0);
        outst    = 1'b1;
        live     = 1'b1;
        req_addr = bus.imem_addr;
        wait_cnt = $urandom_range(lat_max, lat_min) - 1;
      end else begin
        chk("addr_stable", bus.imem_addr, req_addr);
      end
    end else if (outst) begin
      chk("req_held", bus.imem_req, 1);
      outst = 1'b0;
    end

    vld = 1'b0;
    if (outst) begin
      if (wait_cnt == 0) vld = 1'b1;
      else wait_cnt--;
    end
    bus.imem_valid = vld;
    bus.imem_rdata = vld ? mem_word(req_addr) : 16'($urandom);
    if (!outst && $urandom_range(99, 0) < spur_pct) begin
      bus.imem_valid = 1'b1;
      bus.imem_rdata = 16'hF000;
    end
    bus.out_ready = ($urandom_range(99, 0) < ready_pct);

    dead = vld && !live;
    rd   = 1'b0;
    tmp  = 16'($urandom_range(2047, 0));
    rpc  = tmp << 1;
    if (!dead) begin
      if (f_any) begin
        rd = 1'b1; rpc = f_pc; f_any = 1'b0;
      end else if (f_wait && outst && live && !vld) begin
        rd = 1'b1; rpc = f_pc; f_wait = 1'b0;
      end else if (f_valid && vld && live && exp_cnt != 0 && bus.out_ready) begin
        rd = 1'b1; rpc = f_pc; f_valid = 1'b0;
      end else if ($urandom_range(99, 0) < redir_pct) begin
        rd = 1'b1;
      end
    end
    bus.redirect    = rd;
    bus.redirect_pc = rpc;

    if (rd) begin
      exp_q.delete();
      model_pc = rpc;
      halted   = 1'b0;
      if (outst && !vld) live = 1'b0;
    end else if (vld && live) begin
      d = mem_word(req_addr);
      exp_q.push_back({req_addr, d});
      model_pc = model_pc + 16'd2;
      if (d[15:12] == 4'hF) halted = 1'b1;
    end
    vld_last = vld;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // monitor: checks the visible state and scores each accepted entry
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && !in_rst) begin
      chk("out_valid", bus.out_valid, exp_cnt != 0);
      chk("hlt", bus.hlt, exp_hlt);
      if (exp_cnt == DEPTH) chk("full_no_req", bus.imem_req, 0);
      if (bus.out_valid && bus.out_ready && !bus.redirect) begin
        if (exp_q.size() == 0) chk("pop_empty", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("out_pc", bus.out_pc, e[31:16]);
          chk("out_instr", bus.out_instr, e[15:0]);
        end
      end
    end
  end

  initial begin
    bit found;
    bus.imem_valid  = 1'b0;
    bus.imem_rdata  = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready   = 1'b0;
    model_reset();

    #1 rst_n = 1'b0;
    #1;
    chk("rst_req", bus.imem_req, 0);
    chk("rst_addr", bus.imem_addr, RST_PC);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_hlt", bus.hlt, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    in_rst = 1'b0;

    // streaming with 1-cycle memory; starts at FFFE so the PC wraps to 0000
    run(30);

    // decode stalled: queue fills, fetch idles; then drain and resume
    ready_pct = 0;
    run(20);
    ready_pct = 100;
    run(20);

    // redirect while waiting on a 3-cycle memory
    lat_min = 3; lat_max = 3; ready_pct = 60;
    f_pc = 16'h0040; f_wait = 1'b1;
    run(40);
    chk("redirect_in_wait_hit", f_wait, 0);

    // redirect coinciding with a response and a pop
    lat_min = 1; lat_max = 2; ready_pct = 50;
    f_pc = 16'h0100; f_valid = 1'b1;
    run(100);
    chk("redirect_on_valid_hit", f_valid, 0);

    // HLT at 000A; spurious strobes must be ignored while halted
    halt_addr = 16'h000A; spur_pct = 30;
    f_pc = 16'h0000; f_any = 1'b1;
    run(60);
    chk("hlt_reached", bus.hlt, 1);
    halt_addr = 16'hFFFF;
    f_pc = 16'h0000; f_any = 1'b1;
    run(30);

    // random mix
    lat_min = 1; lat_max = 4; ready_pct = 70; redir_pct = 3; spur_pct = 20;
    run(600);

    // asynchronous reset in the middle of a request
    redir_pct = 0; spur_pct = 0; lat_min = 4; lat_max = 4;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (bus.imem_req && outst) found = 1'b1;
    end
    chk("reset_wait_found", bus.imem_req, 1);
    #2 rst_n = 1'b0;
    in_rst = 1'b1;
    #1;
    chk("midrst_req", bus.imem_req, 0);
    chk("midrst_addr", bus.imem_addr, RST_PC);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_hlt", bus.hlt, 0);
    bus.imem_valid = 1'b0;
    bus.redirect   = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    model_reset();
    in_rst = 1'b0;
    lat_min = 1; lat_max = 2; ready_pct = 80;
    run(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
